// File: rtl/pb_narrow_scratch_responder_pkg.sv
// Shared types and constants for the narrow-port scratchpad responder:
// AXI channel structs, response/burst codes, FSM state and scratch geometry.
package pb_narrow_scratch_responder_pkg;

  localparam int unsigned NarrowAddrWidth = 48;
  localparam int unsigned NarrowDataWidth = 64;
  localparam int unsigned NarrowIdWidth   = 4;
  localparam int unsigned NarrowUserWidth = 1;

  localparam int unsigned ScratchNumWords = 256;
  localparam logic [NarrowAddrWidth-1:0] ScratchBaseAddr = 48'h0000_2000_0000;

  typedef logic [1:0] resp_t;
  localparam resp_t RespOkay   = 2'b00;
  localparam resp_t RespExOkay = 2'b01;
  localparam resp_t RespSlvErr = 2'b10;
  localparam resp_t RespDecErr = 2'b11;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic [2:0] {StIdle, StWData, StWAtopR, StBResp, StRData} state_e;
  typedef enum logic {PrioWrite = 1'b0, PrioRead = 1'b1} prio_e;

  // Encoding order makes "worst" a plain max: DECERR > SLVERR > OKAY.
  function automatic resp_t worst_resp(input resp_t a, input resp_t b);
    return (a > b) ? a : b;
  endfunction

  typedef struct packed {
    logic [NarrowIdWidth-1:0]   id;
    logic [NarrowAddrWidth-1:0] addr;
    logic [7:0]                 len;
    logic [2:0]                 size;
    logic [1:0]                 burst;
    logic                       lock;
    logic [3:0]                 cache;
    logic [2:0]                 prot;
    logic [3:0]                 qos;
    logic [3:0]                 region;
    logic [5:0]                 atop;
    logic [NarrowUserWidth-1:0] user;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [NarrowDataWidth-1:0]   data;
    logic [NarrowDataWidth/8-1:0] strb;
    logic                         last;
    logic [NarrowUserWidth-1:0]   user;
  } axi_w_chan_t;

  typedef struct packed {
    logic [NarrowIdWidth-1:0]   id;
    resp_t                      resp;
    logic [NarrowUserWidth-1:0] user;
  } axi_b_chan_t;

  typedef struct packed {
    logic [NarrowIdWidth-1:0]   id;
    logic [NarrowAddrWidth-1:0] addr;
    logic [7:0]                 len;
    logic [2:0]                 size;
    logic [1:0]                 burst;
    logic                       lock;
    logic [3:0]                 cache;
    logic [2:0]                 prot;
    logic [3:0]                 qos;
    logic [3:0]                 region;
    logic [NarrowUserWidth-1:0] user;
  } axi_ar_chan_t;

  typedef struct packed {
    logic [NarrowIdWidth-1:0]   id;
    logic [NarrowDataWidth-1:0] data;
    resp_t                      resp;
    logic                       last;
    logic [NarrowUserWidth-1:0] user;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_narrow_out_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_narrow_out_rsp_t;

endpackage

// File: rtl/pb_axi_beat_addr.sv
// Per-beat address helper: next beat address, scratch word index and the
// error class of the current beat (out of range, or an unsupported burst).
module pb_axi_beat_addr
  import pb_narrow_scratch_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = NarrowAddrWidth,
  parameter int unsigned DataWidth = NarrowDataWidth,
  parameter int unsigned NumWords  = ScratchNumWords,
  parameter logic [AddrWidth-1:0] BaseAddr = ScratchBaseAddr,
  localparam int unsigned IdxWidth = $clog2(NumWords)
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [2:0]           size_i,
  input  logic [1:0]           burst_i,
  output logic [AddrWidth-1:0] next_addr_o,
  output logic [IdxWidth-1:0]  word_idx_o,
  output resp_t                resp_o
);

  localparam int unsigned AddrLsb   = $clog2(DataWidth / 8);
  localparam int unsigned RegionLsb = AddrLsb + IdxWidth;

  logic [AddrWidth-1:0] step;
  logic [AddrWidth-1:0] aligned;
  logic                 in_range;

  always_comb begin
    step        = AddrWidth'(1) << size_i;
    aligned     = addr_i & ~(step - AddrWidth'(1));
    next_addr_o = (burst_i == BurstFixed) ? addr_i : aligned + step;
  end

  // BaseAddr is aligned to the scratch size, so the upper bits alone decide range.
  assign in_range   = (addr_i[AddrWidth-1:RegionLsb] == BaseAddr[AddrWidth-1:RegionLsb]);
  assign word_idx_o = addr_i[AddrLsb +: IdxWidth];

  always_comb begin
    resp_o = RespOkay;
    if (!in_range) begin
      resp_o = RespDecErr;
    end else if (burst_i == BurstWrap || burst_i == 2'b11) begin
      resp_o = RespSlvErr;
    end
  end

endmodule

// File: rtl/pb_narrow_scratch_responder.sv
// AXI4 subordinate terminating the chimney narrow-out port with a register
// scratchpad; one transaction at a time, INCR/FIXED bursts, ATOPs rejected.
module pb_narrow_scratch_responder
  import pb_narrow_scratch_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = NarrowAddrWidth,
  parameter int unsigned DataWidth = NarrowDataWidth,
  parameter int unsigned IdWidth   = NarrowIdWidth,
  parameter int unsigned NumWords  = ScratchNumWords,
  parameter logic [AddrWidth-1:0] BaseAddr = ScratchBaseAddr,
  parameter type axi_req_t = axi_narrow_out_req_t,
  parameter type axi_rsp_t = axi_narrow_out_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o,
  output logic     busy_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxWidth  = $clog2(NumWords);

  state_e               state_q, state_d;
  prio_e                prio_q, prio_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [7:0]           len_q, len_d;
  logic [2:0]           size_q, size_d;
  logic [1:0]           burst_q, burst_d;
  logic [5:0]           atop_q, atop_d;
  logic [7:0]           cnt_q, cnt_d;
  resp_t                err_q, err_d;

  logic [DataWidth-1:0] mem_q [NumWords];

  logic [AddrWidth-1:0] beat_next_addr;
  logic [IdxWidth-1:0]  beat_idx;
  resp_t                beat_resp;
  logic                 beat_last, aw_grant, ar_grant, mem_we;
  logic                 unused_req;

  assign unused_req = ^axi_req_i;

  pb_axi_beat_addr #(
    .AddrWidth(AddrWidth),
    .DataWidth(DataWidth),
    .NumWords (NumWords),
    .BaseAddr (BaseAddr)
  ) i_beat_addr (
    .addr_i     (addr_q),
    .size_i     (size_q),
    .burst_i    (burst_q),
    .next_addr_o(beat_next_addr),
    .word_idx_o (beat_idx),
    .resp_o     (beat_resp)
  );

  assign beat_last = (cnt_q == len_q);
  assign aw_grant  = (state_q == StIdle) && axi_req_i.aw_valid &&
                     (!axi_req_i.ar_valid || prio_q == PrioWrite);
  assign ar_grant  = (state_q == StIdle) && axi_req_i.ar_valid &&
                     (!axi_req_i.aw_valid || prio_q == PrioRead);
  assign mem_we    = (state_q == StWData) && axi_req_i.w_valid &&
                     (beat_resp == RespOkay) && (atop_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      prio_q  <= PrioWrite;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      atop_q  <= '0;
      cnt_q   <= '0;
      err_q   <= RespOkay;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      atop_q  <= atop_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    atop_d  = atop_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (aw_grant) begin
          id_d    = axi_req_i.aw.id;
          addr_d  = axi_req_i.aw.addr;
          len_d   = axi_req_i.aw.len;
          size_d  = axi_req_i.aw.size;
          burst_d = axi_req_i.aw.burst;
          atop_d  = axi_req_i.aw.atop;
          cnt_d   = '0;
          err_d   = (axi_req_i.aw.atop != '0) ? RespSlvErr : RespOkay;
          prio_d  = PrioRead;
          state_d = StWData;
        end else if (ar_grant) begin
          id_d    = axi_req_i.ar.id;
          addr_d  = axi_req_i.ar.addr;
          len_d   = axi_req_i.ar.len;
          size_d  = axi_req_i.ar.size;
          burst_d = axi_req_i.ar.burst;
          atop_d  = '0;
          cnt_d   = '0;
          err_d   = RespOkay;
          prio_d  = PrioWrite;
          state_d = StRData;
        end
      end
      StWData: begin
        if (axi_req_i.w_valid) begin
          err_d  = worst_resp(err_q, beat_resp);
          addr_d = beat_next_addr;
          cnt_d  = cnt_q + 8'd1;
          if (beat_last) begin
            cnt_d   = '0;
            state_d = atop_q[5] ? StWAtopR : StBResp;
          end
        end
      end
      StWAtopR: begin
        if (axi_req_i.r_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (beat_last) begin
            cnt_d   = '0;
            state_d = StBResp;
          end
        end
      end
      StBResp: begin
        if (axi_req_i.b_ready) state_d = StIdle;
      end
      StRData: begin
        if (axi_req_i.r_ready) begin
          addr_d = beat_next_addr;
          cnt_d  = cnt_q + 8'd1;
          if (beat_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    axi_rsp_o          = '0;
    busy_o             = (state_q != StIdle);
    axi_rsp_o.aw_ready = aw_grant;
    axi_rsp_o.ar_ready = ar_grant;
    case (state_q)
      StWData: axi_rsp_o.w_ready = 1'b1;
      StWAtopR: begin
        axi_rsp_o.r_valid = 1'b1;
        axi_rsp_o.r.id    = id_q;
        axi_rsp_o.r.resp  = RespSlvErr;
        axi_rsp_o.r.last  = beat_last;
      end
      StBResp: begin
        axi_rsp_o.b_valid = 1'b1;
        axi_rsp_o.b.id    = id_q;
        axi_rsp_o.b.resp  = err_q;
      end
      StRData: begin
        axi_rsp_o.r_valid = 1'b1;
        axi_rsp_o.r.id    = id_q;
        axi_rsp_o.r.data  = (beat_resp == RespOkay) ? mem_q[beat_idx] : '0;
        axi_rsp_o.r.resp  = beat_resp;
        axi_rsp_o.r.last  = beat_last;
      end
      default: ;
    endcase
  end

  // Read data is taken straight from the array; no writes can overlap a read burst.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumWords; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      for (int b = 0; b < StrbWidth; b++) begin
        if (axi_req_i.w.strb[b]) mem_q[beat_idx][b*8 +: 8] <= axi_req_i.w.data[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_pb_narrow_scratch_responder.sv
// Directed bench for the narrow scratch responder: stimulus pushes expected
// B/R responses into queues, a negedge monitor pops and compares on handshakes.
module tb_pb_narrow_scratch_responder;
  import pb_narrow_scratch_responder_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  axi_narrow_out_req_t req;
  axi_narrow_out_rsp_t rsp;
  logic                busy;

  always #5 clk = ~clk;

  pb_narrow_scratch_responder dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .axi_req_i(req),
    .axi_rsp_o(rsp),
    .busy_o   (busy)
  );

  typedef struct {
    logic [3:0] id;
    resp_t      resp;
  } exp_b_t;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    resp_t       resp;
    logic        last;
  } exp_r_t;

  exp_b_t exp_b[$];
  exp_r_t exp_r[$];
  exp_b_t eb;
  exp_r_t er;
  int     total = 0;
  int     bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_b(input logic [3:0] id, input resp_t resp);
    exp_b_t e;
    e.id = id; e.resp = resp;
    exp_b.push_back(e);
  endtask

  task automatic push_r(input logic [3:0] id, input logic [63:0] data, input resp_t resp,
                        input logic last);
    exp_r_t e;
    e.id = id; e.data = data; e.resp = resp; e.last = last;
    exp_r.push_back(e);
  endtask

  // Monitor: one line per B/R handshake, compared against the queue heads.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp.b_valid && req.b_ready) begin
        $display("B  id=%0d resp=%0d", rsp.b.id, rsp.b.resp);
        if (exp_b.size() == 0) begin
          check("b_unexpected", 64'd1, 64'd0);
        end else begin
          eb = exp_b.pop_front();
          check("b_id", 64'(rsp.b.id), 64'(eb.id));
          check("b_resp", 64'(rsp.b.resp), 64'(eb.resp));
          check("b_after_r", 64'(exp_r.size()), 64'd0);
        end
      end
      if (rsp.r_valid && req.r_ready) begin
        $display("R  id=%0d data=%h resp=%0d last=%0d", rsp.r.id, rsp.r.data, rsp.r.resp, rsp.r.last);
        if (exp_r.size() == 0) begin
          check("r_unexpected", 64'd1, 64'd0);
        end else begin
          er = exp_r.pop_front();
          check("r_id", 64'(rsp.r.id), 64'(er.id));
          check("r_data", rsp.r.data, er.data);
          check("r_resp", 64'(rsp.r.resp), 64'(er.resp));
          check("r_last", 64'(rsp.r.last), 64'(er.last));
        end
      end
    end
  end

  task automatic grab_aw();
    int n = 0;
    do begin @(negedge clk); n++; end while (!rsp.aw_ready && n < 100);
    if (!rsp.aw_ready) check("aw_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
  endtask

  task automatic grab_ar();
    int n = 0;
    do begin @(negedge clk); n++; end while (!rsp.ar_ready && n < 100);
    if (!rsp.ar_ready) check("ar_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [5:0] atop);
    req.aw       = '0;
    req.aw.id    = id;
    req.aw.addr  = addr;
    req.aw.len   = len;
    req.aw.size  = 3'd3;
    req.aw.burst = burst;
    req.aw.atop  = atop;
    req.aw_valid = 1'b1;
    grab_aw();
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [47:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    req.ar       = '0;
    req.ar.id    = id;
    req.ar.addr  = addr;
    req.ar.len   = len;
    req.ar.size  = 3'd3;
    req.ar.burst = burst;
    req.ar_valid = 1'b1;
    grab_ar();
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    req.w.data  = data;
    req.w.strb  = strb;
    req.w.last  = last;
    req.w_valid = 1'b1;
    do begin @(negedge clk); n++; end while (!rsp.w_ready && n < 100);
    if (!rsp.w_ready) check("w_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req.w_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!busy && exp_b.size() == 0 && exp_r.size() == 0) break;
    end
    if (n == 2000) check("idle_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] v;
    int n;
    req = '0;
    req.b_ready = 1'b1;
    req.r_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", 64'({rsp.aw_ready, rsp.w_ready, rsp.ar_ready, rsp.b_valid, rsp.r_valid, busy}), 64'd0);

    // Arbitration: AW first after reset, AR next time both are valid in IDLE.
    @(posedge clk); #1;
    req.aw = '0; req.aw.id = 4'd1; req.aw.addr = 48'h0000_2000_0018; req.aw.size = 3'd3; req.aw.burst = BurstIncr;
    req.ar = '0; req.ar.id = 4'd2; req.ar.addr = 48'h0000_2000_0000; req.ar.size = 3'd3; req.ar.burst = BurstIncr;
    req.aw_valid = 1'b1;
    req.ar_valid = 1'b1;
    push_b(4'd1, RespOkay);
    @(negedge clk);
    check("arb_aw_first", 64'({rsp.aw_ready, rsp.ar_ready}), 64'b10);
    @(posedge clk); #1 req.aw_valid = 1'b0;
    send_w(64'h5555_6666_7777_8888, 8'hFF, 1'b1);
    req.aw.id = 4'd4; req.aw.addr = 48'h0000_2000_0020;
    req.aw_valid = 1'b1;
    push_b(4'd4, RespOkay);
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp.ar_ready || rsp.aw_ready) break;
    end
    check("arb_ar_second", 64'({rsp.aw_ready, rsp.ar_ready}), 64'b01);
    push_r(4'd2, 64'h0, RespOkay, 1'b1);
    @(posedge clk); #1 req.ar_valid = 1'b0;
    grab_aw();
    send_w(64'h9999_AAAA_BBBB_CCCC, 8'hFF, 1'b1);
    wait_idle();

    // Partial strobe into a zero word.
    push_b(4'd5, RespOkay);
    send_aw(4'd5, 48'h0000_2000_0010, 8'd0, BurstIncr, 6'd0);
    send_w(64'hAABB_CCDD_EEFF_0011, 8'h0F, 1'b1);
    wait_idle();
    push_r(4'd6, 64'h0000_0000_EEFF_0011, RespOkay, 1'b1);
    send_ar(4'd6, 48'h0000_2000_0010, 8'd0, BurstIncr);
    wait_idle();

    // INCR len=3 write then read back.
    push_b(4'd3, RespOkay);
    send_aw(4'd3, 48'h0000_2000_0000, 8'd3, BurstIncr, 6'd0);
    for (int i = 0; i < 4; i++) begin
      v = 64'h1111_1111_1111_1111 * 64'(i + 1);
      send_w(v, 8'hFF, i == 3);
    end
    wait_idle();
    for (int i = 0; i < 4; i++) push_r(4'd5, 64'h1111_1111_1111_1111 * 64'(i + 1), RespOkay, i == 3);
    send_ar(4'd5, 48'h0000_2000_0000, 8'd3, BurstIncr);
    wait_idle();

    // Top word of the scratch, then a read crossing the end.
    push_b(4'd7, RespOkay);
    send_aw(4'd7, 48'h0000_2000_07F8, 8'd0, BurstIncr, 6'd0);
    send_w(64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b1);
    wait_idle();
    push_r(4'd8, 64'hDEAD_BEEF_0123_4567, RespOkay, 1'b0);
    push_r(4'd8, 64'h0, RespDecErr, 1'b1);
    send_ar(4'd8, 48'h0000_2000_07F8, 8'd1, BurstIncr);
    wait_idle();

    // Out-of-range write aliases word 0 in its low bits; it must not land.
    push_b(4'd9, RespDecErr);
    send_aw(4'd9, 48'h0000_3000_0000, 8'd0, BurstIncr, 6'd0);
    send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    wait_idle();
    push_r(4'd10, 64'h1111_1111_1111_1111, RespOkay, 1'b1);
    send_ar(4'd10, 48'h0000_2000_0000, 8'd0, BurstIncr);
    wait_idle();

    // Atomic with response data: R SLVERR before B SLVERR, no update.
    push_r(4'd11, 64'h0, RespSlvErr, 1'b1);
    push_b(4'd11, RespSlvErr);
    send_aw(4'd11, 48'h0000_2000_0008, 8'd0, BurstIncr, 6'b100000);
    send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    wait_idle();
    push_r(4'd12, 64'h2222_2222_2222_2222, RespOkay, 1'b1);
    send_ar(4'd12, 48'h0000_2000_0008, 8'd0, BurstIncr);
    wait_idle();

    // WRAP bursts are rejected on every beat.
    push_b(4'd13, RespSlvErr);
    send_aw(4'd13, 48'h0000_2000_0040, 8'd1, BurstWrap, 6'd0);
    send_w(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
    send_w(64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    wait_idle();
    push_r(4'd14, 64'h0, RespSlvErr, 1'b0);
    push_r(4'd14, 64'h0, RespSlvErr, 1'b1);
    send_ar(4'd14, 48'h0000_2000_0000, 8'd1, BurstWrap);
    wait_idle();
    push_r(4'd15, 64'h0, RespOkay, 1'b1);
    send_ar(4'd15, 48'h0000_2000_0040, 8'd0, BurstIncr);
    wait_idle();

    // FIXED burst: both beats hit the same word.
    push_b(4'd6, RespOkay);
    send_aw(4'd6, 48'h0000_2000_0030, 8'd1, BurstFixed, 6'd0);
    send_w(64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 1'b0);
    send_w(64'h5A5A_0000_5A5A_0000, 8'hFF, 1'b1);
    wait_idle();
    push_r(4'd7, 64'h5A5A_0000_5A5A_0000, RespOkay, 1'b0);
    push_r(4'd7, 64'h5A5A_0000_5A5A_0000, RespOkay, 1'b1);
    send_ar(4'd7, 48'h0000_2000_0030, 8'd1, BurstFixed);
    wait_idle();

    // Reset during beat 2 of a len=7 read stalled by r_ready=0.
    req.r_ready = 1'b0;
    push_r(4'd1, 64'h1111_1111_1111_1111, RespOkay, 1'b0);
    push_r(4'd1, 64'h2222_2222_2222_2222, RespOkay, 1'b0);
    send_ar(4'd1, 48'h0000_2000_0000, 8'd7, BurstIncr);
    req.r_ready = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    req.r_ready = 1'b0;
    @(negedge clk);
    check("stall_beat2_valid", 64'(rsp.r_valid), 64'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    req.ar = '0; req.ar.id = 4'd2; req.ar.addr = 48'h0000_2000_0008; req.ar.size = 3'd3; req.ar.burst = BurstIncr;
    req.ar_valid = 1'b1;
    @(negedge clk);
    check("rst_r_valid", 64'(rsp.r_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ar_accept", 64'(rsp.ar_ready), 64'd1);
    push_r(4'd2, 64'h0, RespOkay, 1'b1);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    req.r_ready = 1'b1;
    wait_idle();

    check("leftover_expected", 64'(exp_b.size() + exp_r.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
